// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scancode decoder: tracks prefixes (E0/F0/E1), held state of the
// game keys, and the last completed make code for the hex display.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned PAUSE_SKIP     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic       new_event,
  output logic       left_held,
  output logic       right_held,
  output logic       jump_held,
  output logic       jump_press,
  output logic       esc_press,
  output logic [7:0] last_code,
  output logic       last_ext,
  output logic       code_valid
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SW = (PAUSE_SKIP > 7) ? $clog2(PAUSE_SKIP + 1) : 3;
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SKIP_LOAD = SW'(PAUSE_SKIP);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  function automatic logic is_ctrl(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_ctrl = 1'b1;
      default:                                  is_ctrl = 1'b0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   skip_q, skip_d;
  logic            a_q, a_d, lx_q, lx_d, d_q, d_d, rx_q, rx_d;
  logic            jump_q, jump_d, esc_q, esc_d;
  logic            left_q, left_d, right_q, right_d;
  logic            jump_press_q, jump_press_d, esc_press_q, esc_press_d;
  logic [7:0]      last_code_q, last_code_d;
  logic            last_ext_q, last_ext_d, code_valid_q, code_valid_d;
  logic            make_ev, brk_ev, ev_ext;

  // Next-state: prefix FSM, timeout/skip counters, and key-state updates.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    skip_d       = skip_q;
    a_d          = a_q;
    lx_d         = lx_q;
    d_d          = d_q;
    rx_d         = rx_q;
    jump_d       = jump_q;
    esc_d        = esc_q;
    jump_press_d = 1'b0;
    esc_press_d  = 1'b0;
    code_valid_d = 1'b0;
    last_code_d  = last_code_q;
    last_ext_d   = last_ext_q;
    make_ev      = 1'b0;
    brk_ev       = 1'b0;
    ev_ext       = 1'b0;

    if (new_event) begin
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (key == 8'hE0) begin
            state_d = S_EXT;
          end else if (key == 8'hF0) begin
            state_d = S_BRK;
          end else if (key == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = SKIP_LOAD;
          end else if (is_ctrl(key)) begin
            state_d = S_IDLE;
          end else begin
            make_ev = 1'b1;
          end
        end
        S_EXT: begin
          if (key == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else if (key == 8'hE0) begin
            state_d = S_EXT;
          end else begin
            make_ev = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (key == 8'hF0) begin
            state_d = S_BRK;
          end else if (key == 8'hE0) begin
            state_d = S_EXT_BRK;
          end else begin
            brk_ev  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if ((key == 8'hF0) || (key == 8'hE0)) begin
            state_d = S_EXT_BRK;
          end else begin
            brk_ev  = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_SKIP: begin
          skip_d = skip_q - SW'(1);
          if (skip_q <= SW'(1)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SKIP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // A pending prefix with no follow-up byte is abandoned silently.
      if (cnt_q == TO_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end

    if (make_ev) begin
      last_code_d  = key;
      last_ext_d   = ev_ext;
      code_valid_d = 1'b1;
      if (ev_ext) begin
        case (key)
          8'h6B:   lx_d = 1'b1;
          8'h74:   rx_d = 1'b1;
          default: lx_d = lx_q;
        endcase
      end else begin
        case (key)
          8'h1C: a_d = 1'b1;
          8'h23: d_d = 1'b1;
          8'h29: begin
            jump_d       = 1'b1;
            jump_press_d = ~jump_q;
          end
          8'h76: begin
            esc_d       = 1'b1;
            esc_press_d = ~esc_q;
          end
          default: a_d = a_q;
        endcase
      end
    end else if (brk_ev) begin
      if (ev_ext) begin
        case (key)
          8'h6B:   lx_d = 1'b0;
          8'h74:   rx_d = 1'b0;
          default: lx_d = lx_q;
        endcase
      end else begin
        case (key)
          8'h1C:   a_d    = 1'b0;
          8'h23:   d_d    = 1'b0;
          8'h29:   jump_d = 1'b0;
          8'h76:   esc_d  = 1'b0;
          default: a_d    = a_q;
        endcase
      end
    end else begin
      last_code_d = last_code_q;
    end

    left_d  = a_d | lx_d;
    right_d = d_d | rx_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      skip_q       <= '0;
      a_q          <= 1'b0;
      lx_q         <= 1'b0;
      d_q          <= 1'b0;
      rx_q         <= 1'b0;
      jump_q       <= 1'b0;
      esc_q        <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      jump_press_q <= 1'b0;
      esc_press_q  <= 1'b0;
      last_code_q  <= 8'h00;
      last_ext_q   <= 1'b0;
      code_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      skip_q       <= skip_d;
      a_q          <= a_d;
      lx_q         <= lx_d;
      d_q          <= d_d;
      rx_q         <= rx_d;
      jump_q       <= jump_d;
      esc_q        <= esc_d;
      left_q       <= left_d;
      right_q      <= right_d;
      jump_press_q <= jump_press_d;
      esc_press_q  <= esc_press_d;
      last_code_q  <= last_code_d;
      last_ext_q   <= last_ext_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign left_held  = left_q;
  assign right_held = right_q;
  assign jump_held  = jump_q;
  assign jump_press = jump_press_q;
  assign esc_press  = esc_press_q;
  assign last_code  = last_code_q;
  assign last_ext   = last_ext_q;
  assign code_valid = code_valid_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: each driven byte pushes its expected
// output vector, which is popped and compared one cycle later.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key;
  logic       new_event;
  logic       left_held, right_held, jump_held, jump_press, esc_press;
  logic [7:0] last_code;
  logic       last_ext, code_valid;

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(16), .PAUSE_SKIP(7)) dut (
    .clk(clk), .rst(rst), .key(key), .new_event(new_event),
    .left_held(left_held), .right_held(right_held), .jump_held(jump_held),
    .jump_press(jump_press), .esc_press(esc_press), .last_code(last_code),
    .last_ext(last_ext), .code_valid(code_valid)
  );

  // Vector layout: {left, right, jump, jump_press, esc_press, last_ext, code_valid, last_code}
  typedef logic [14:0] vec_t;
  localparam vec_t PULSE_MASK = 15'b000110100000000;

  vec_t sb_q[$];
  vec_t cur;
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t obs_vec();
    return {left_held, right_held, jump_held, jump_press, esc_press,
            last_ext, code_valid, last_code};
  endfunction

  task automatic check_eq(input string tag, input vec_t obs, input vec_t exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // flags = {left, right, jump, jump_press, esc_press, last_ext, code_valid}
  task automatic send(input string tag, input logic [7:0] b,
                      input logic [6:0] flags, input logic [7:0] code);
    vec_t e;
    @(negedge clk);
    key       = b;
    new_event = 1'b1;
    e = {flags, code};
    sb_q.push_back(e);
    cur = e & ~PULSE_MASK;
    @(posedge clk);
    #1;
    new_event = 1'b0;
    key       = 8'h00;
    if (sb_q.size() == 0) check_eq({tag, "_empty"}, obs_vec(), ~cur);
    else check_eq(tag, obs_vec(), sb_q.pop_front());
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_eq(tag, obs_vec(), cur);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cur = '0;
    check_eq(tag, obs_vec(), cur);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [7:0] pause_seq [8];

  initial begin
    rst       = 1'b0;
    key       = 8'h00;
    new_event = 1'b0;
    cur       = '0;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_init", obs_vec(), cur);
    @(negedge clk);
    rst = 1'b1;
    idle("after_reset", 2);

    send("make29", 8'h29, 7'b0011001, 8'h29);
    idle("hold29", 2);
    send("brk_f0", 8'hF0, 7'b0010000, 8'h29);
    send("brk29",  8'h29, 7'b0000000, 8'h29);

    send("typ1",   8'h29, 7'b0011001, 8'h29);
    send("typ2",   8'h29, 7'b0010001, 8'h29);
    send("typ3",   8'h29, 7'b0010001, 8'h29);
    send("rel_f0", 8'hF0, 7'b0010000, 8'h29);
    send("rel29",  8'h29, 7'b0000000, 8'h29);

    send("ext_e0", 8'hE0, 7'b0000000, 8'h29);
    send("ext74",  8'h74, 7'b0100011, 8'h74);
    send("xb_e0",  8'hE0, 7'b0100010, 8'h74);
    send("xb_f0",  8'hF0, 7'b0100010, 8'h74);
    send("xb74",   8'h74, 7'b0000010, 8'h74);
    send("kp74",   8'h74, 7'b0000001, 8'h74);

    send("a1c",     8'h1C, 7'b1000001, 8'h1C);
    send("l_e0",    8'hE0, 7'b1000000, 8'h1C);
    send("x6b",     8'h6B, 7'b1000011, 8'h6B);
    send("l_f0",    8'hF0, 7'b1000010, 8'h6B);
    send("rel1c",   8'h1C, 7'b1000010, 8'h6B);
    send("lx_e0",   8'hE0, 7'b1000010, 8'h6B);
    send("lx_f0",   8'hF0, 7'b1000010, 8'h6B);
    send("rel_x6b", 8'h6B, 7'b0000010, 8'h6B);

    foreach (pause_seq[i]) send("pause", pause_seq[i], 7'b0000010, 8'h6B);
    idle("pause_idle", 1);
    send("esc",     8'h76, 7'b0000101, 8'h76);
    idle("esc_pulse_end", 1);
    send("esc_rpt", 8'h76, 7'b0000001, 8'h76);
    send("esc_f0",  8'hF0, 7'b0000000, 8'h76);
    send("esc_brk", 8'h76, 7'b0000000, 8'h76);
    send("esc2",    8'h76, 7'b0000101, 8'h76);

    send("to_f0",   8'hF0, 7'b0000000, 8'h76);
    idle("to_wait", 16);
    send("to_make", 8'h29, 7'b0011001, 8'h29);

    send("ctl_aa",  8'hAA, 7'b0010000, 8'h29);
    send("ctl_fa",  8'hFA, 7'b0010000, 8'h29);

    send("exp_f0",  8'hF0, 7'b0010000, 8'h29);
    idle("exp_wait", 15);
    send("exp_brk", 8'h29, 7'b0000000, 8'h29);

    send("mid_e0",  8'hE0, 7'b0000000, 8'h29);
    do_reset("mid_reset");
    send("post_rst74", 8'h74, 7'b0000001, 8'h74);
    idle("final", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
